sos_cascade_sequencer: RTL and testbench

Sequences one shared second-order-section (SOS) biquad datapath through an `N_STAGES`-deep IIR cascade, one input sample at a time.

- Accepts narrow samples on a valid/ready port and sign- or zero-extends them to the accumulator width.
- Issues the sample to the shared section once per stage, passing each section result back in as the next stage's input and driving the coefficient-bank index.
- Returns the final cascade output on a valid/ready port.
- Sits between the sample source and the single instantiated biquad/MAC core.

---
 rtl/sos_cascade_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sos_cascade_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sos_cascade_sequencer.sv
// Sequences one shared biquad section through an N_STAGES IIR cascade, one sample at a time.
// Optional output clamp to the sample range: define SOS_SEQ_SAT_EN (adds sat_o).
module sos_cascade_sequencer #(
    parameter int unsigned S_WD     = 16,
    parameter int unsigned L_WD     = 32,
    parameter int unsigned N_STAGES = 4,
    parameter int unsigned TMO_CYC  = 64,
    parameter int unsigned IDX_WD   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [S_WD-1:0]   in_data_i,
    input  logic              signed_i,
    output logic              sec_start_o,
    output logic [IDX_WD-1:0] sec_idx_o,
    output logic [L_WD-1:0]   sec_data_o,
    input  logic              sec_valid_i,
    input  logic [L_WD-1:0]   sec_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [L_WD-1:0]   out_data_o,
    output logic              busy_o,
`ifdef SOS_SEQ_SAT_EN
    output logic              sat_o,
`endif
    output logic              err_o
);

    localparam int unsigned CntWd = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDX_WD-1:0] idx_q, idx_d;
    logic [L_WD-1:0]   opnd_q, opnd_d;
    logic              signed_q, signed_d;
    logic [CntWd-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              sec_start_q;
    logic [IDX_WD-1:0] sec_idx_q;
    logic [L_WD-1:0]   sec_data_q;
    logic              out_valid_q;
    logic [L_WD-1:0]   out_data_q;
    logic [L_WD-1:0]   ext_data;
    logic [L_WD-1:0]   res_val;
    logic              res_clamped;
    logic              enter_done;

    assign ext_data = {{(L_WD-S_WD){signed_i & in_data_i[S_WD-1]}}, in_data_i};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opnd_d   = opnd_q;
        signed_d = signed_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (sec_valid_i) err_d = 1'b1;
                if (in_valid_i) begin
                    signed_d = signed_i;
                    opnd_d   = ext_data;
                    idx_d    = '0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (sec_valid_i) err_d = 1'b1;
                // The launch cycle itself counts as the first cycle of the wait budget.
                cnt_d   = CntWd'(1);
                state_d = StWait;
            end
            StWait: begin
                if (sec_valid_i) begin
                    opnd_d = sec_data_i;
                    if (idx_q == IDX_WD'(N_STAGES - 1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StIssue;
                    end
                end else if (cnt_q == CntWd'(TMO_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (sec_valid_i) err_d = 1'b1;
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign enter_done = (state_q == StWait) && (state_d == StDone);

`ifdef SOS_SEQ_SAT_EN
    localparam logic [L_WD-1:0] SMax = {{(L_WD-S_WD+1){1'b0}}, {(S_WD-1){1'b1}}};
    localparam logic [L_WD-1:0] SMin = ~SMax;
    localparam logic [L_WD-1:0] UMax = {{(L_WD-S_WD){1'b0}}, {S_WD{1'b1}}};

    logic sat_q;

    always_comb begin
        res_val     = sec_data_i;
        res_clamped = 1'b0;
        if (signed_q) begin
            // In range iff every bit from the sample sign bit upward matches the MSB.
            if (sec_data_i[L_WD-1:S_WD-1] != {(L_WD-S_WD+1){sec_data_i[L_WD-1]}}) begin
                res_clamped = 1'b1;
                res_val     = sec_data_i[L_WD-1] ? SMin : SMax;
            end
        end else if (sec_data_i[L_WD-1]) begin
            res_clamped = 1'b1;
            res_val     = '0;
        end else if ((sec_data_i >> S_WD) != '0) begin
            res_clamped = 1'b1;
            res_val     = UMax;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
        end else if (enter_done) begin
            sat_q <= res_clamped;
        end else if (state_d != StDone) begin
            sat_q <= 1'b0;
        end
    end

    assign sat_o = sat_q;
`else
    assign res_val     = sec_data_i;
    assign res_clamped = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            opnd_q      <= '0;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            sec_start_q <= 1'b0;
            sec_idx_q   <= '0;
            sec_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            opnd_q      <= opnd_d;
            signed_q    <= signed_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            sec_start_q <= (state_d == StIssue);
            out_valid_q <= (state_d == StDone);
            if (state_d == StIssue) begin
                sec_idx_q  <= idx_d;
                sec_data_q <= opnd_d;
            end
            if (enter_done) out_data_q <= res_val;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign sec_start_o = sec_start_q;
    assign sec_idx_o   = sec_idx_q;
    assign sec_data_o  = sec_data_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// Directed bench for sos_cascade_sequencer; section model returns input+1 three cycles after start.
module tb_sos_cascade_sequencer;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        sgn = 1'b0;
    logic        sec_start;
    logic [1:0]  sec_idx;
    logic [31:0] sec_data_o;
    logic        sec_valid;
    logic [31:0] sec_data_i;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;
    logic        err;
`ifdef SOS_SEQ_SAT_EN
    logic        sat;
`endif

    int          n_checks = 0;
    int          n_fail = 0;

    // Section model state
    int          pend = 0;
    int          drop_idx = -1;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    logic [31:0] resp = '0;
    logic        mdl_valid = 1'b0;
    logic [31:0] mdl_data = '0;
    logic        spur = 1'b0;

    assign sec_valid  = mdl_valid | spur;
    assign sec_data_i = mdl_data;

    sos_cascade_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .signed_i    (sgn),
        .sec_start_o (sec_start),
        .sec_idx_o   (sec_idx),
        .sec_data_o  (sec_data_o),
        .sec_valid_i (sec_valid),
        .sec_data_i  (sec_data_i),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy),
`ifdef SOS_SEQ_SAT_EN
        .sat_o       (sat),
`endif
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Valid is raised on the third negedge after start, so the DUT samples it L=3 cycles later.
    always @(negedge clk) begin
        mdl_valid = 1'b0;
        if (!rst_ni) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mdl_valid = 1'b1;
                    mdl_data  = resp;
                end
            end
            if (sec_start && int'(sec_idx) != drop_idx) begin
                pend = 3;
                resp = ovr_en ? ovr_val : sec_data_o + 32'd1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_sample(input logic [15:0] d, input logic s, input logic [31:0] exp_first,
                              input logic [31:0] exp_out);
        int lat;
        int nst;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        sgn      = s;
        lat = 0;
        nst = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (sec_start) begin
                if (nst == 0) check_eq("first_sec_data", sec_data_o, exp_first);
                check_eq("sec_idx", sec_idx, nst);
                nst++;
            end
        end while (!out_valid && lat < 60);
        check_eq("latency", lat, 17);
        check_eq("n_starts", nst, 4);
        check_eq("out_data", out_data, exp_out);
        check_eq("busy_done", busy, 1);
    endtask

    task automatic handshake(input int hold, input logic [31:0] exp_out);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_data", out_data, exp_out);
            check_eq("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("hs_in_ready", in_ready, 1);
        check_eq("hs_out_valid", out_valid, 0);
        check_eq("hs_busy", busy, 0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_sec_start", sec_start, 0);
        check_eq("rst_sec_idx", sec_idx, 0);
        check_eq("rst_sec_data", sec_data_o, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
    endtask

    initial begin
        int n;
        int guard;
        int lat;
        logic seen_ov;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_ni = 1'b1;

        // Signed extend, then 10 cycles of backpressure
        run_sample(16'h8001, 1'b1, 32'hFFFF8001, 32'hFFFF8005);
        handshake(10, 32'hFFFF8005);

        // Unsigned extend
        run_sample(16'h8001, 1'b0, 32'h00008001, 32'h00008005);
        handshake(0, 32'h00008005);

        // Timeout: no response to stage 2
        drop_idx = 2;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0010;
        sgn      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 40) begin
            if (sec_start) n++;
            if (n < 3) begin
                @(negedge clk);
                guard++;
            end
        end
        check_eq("tmo_starts", n, 3);
        check_eq("tmo_err_before", err, 0);
        seen_ov = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1'b1;
            if (in_ready) begin
                lat = k;
                break;
            end
        end
        check_eq("tmo_cycles", lat, 64);
        check_eq("tmo_err", err, 1);
        check_eq("tmo_no_out_valid", seen_ov, 0);
        drop_idx = -1;

        // Reset while waiting on stage 1
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        sgn      = 1'b1;
        n = 0;
        guard = 0;
        while (n < 2 && guard < 40) begin
            @(negedge clk);
            in_valid = 1'b0;
            guard++;
            if (sec_start) n++;
        end
        @(negedge clk);
        check_eq("mid_busy", busy, 1);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        run_sample(16'h0005, 1'b1, 32'h00000005, 32'h00000009);
        handshake(0, 32'h00000009);

`ifdef SOS_SEQ_SAT_EN
        ovr_en  = 1'b1;
        ovr_val = 32'h00012345;
        run_sample(16'h0001, 1'b1, 32'h00000001, 32'h00007FFF);
        check_eq("sat_pos", sat, 1);
        handshake(0, 32'h00007FFF);
        ovr_val = 32'hFFFFFFF0;
        run_sample(16'h0001, 1'b0, 32'h00000001, 32'h00000000);
        check_eq("sat_uns_neg", sat, 1);
        handshake(0, 32'h00000000);
        ovr_en = 1'b0;
`endif

        // Spurious result while idle
        check_eq("pre_spur_err", err, 0);
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check_eq("spur_err", err, 1);
        check_eq("spur_in_ready", in_ready, 1);
        @(negedge clk);
        check_eq("spur_err_sticky", err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
